// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block sequencing logic.
package sha256_pkg;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);

    localparam logic [255:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sha256_block_buf.sv
// 16x32 message-block register file: one synchronous write port, one async read port.
module sha256_block_buf
    import sha256_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  word_t            wdata,
    input  logic [IDX_W-1:0] raddr,
    output word_t            rdata
);

    word_t mem [WORDS_PER_BLOCK];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sha256_block_sequencer.sv
// Buffers one 512-bit block from the host, streams it into the SHA-256 core,
// chains H across blocks and hands the final digest back over valid/ready.
module sha256_block_sequencer #(
    parameter int WORDS_PER_BLOCK = 16,
    parameter int BLOCK_CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  sha256_pkg::word_t      in_word,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [255:0]           digest,
    output logic                   busy,
    output logic [BLOCK_CNT_W-1:0] block_cnt,
    output logic                   err,
    output logic                   core_start,
    output logic                   core_first,
    output sha256_pkg::word_t      core_w,
    output logic [255:0]           core_h_in,
    input  logic [255:0]           core_h_out,
    input  logic                   core_done
);

    import sha256_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [IDX_W-1:0] idx;
    logic             last_f;
    logic             first;
    logic [255:0]     chain;
    word_t            buf_rdata;
    logic             accept;

    assign accept = (state == LOAD) && in_valid;

    // One index serves as write pointer in LOAD and read pointer in FEED.
    sha256_block_buf u_block_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (idx),
        .wdata (in_word),
        .raddr (idx),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        digest     = '0;
        core_start = 1'b0;
        core_first = 1'b0;
        core_w     = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (idx == LAST_IDX)) state_next = FEED;
            end
            FEED: begin
                core_w     = buf_rdata;
                core_start = (idx == '0);
                core_first = first;
                if (idx == LAST_IDX) state_next = WAIT;
            end
            WAIT: begin
                core_first = first;
                if (core_done) state_next = last_f ? OUT : LOAD;
            end
            OUT: begin
                out_valid = 1'b1;
                digest    = chain;
                if (out_ready) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    assign core_h_in = chain;
    assign busy      = !((state == LOAD) && (idx == '0) && first);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            last_f    <= 1'b0;
            first     <= 1'b1;
            chain     <= SHA256_IV;
            block_cnt <= '0;
            err       <= 1'b0;
        end else begin
            // A done pulse is only legal while waiting on the core.
            if (core_done && (state != WAIT)) err <= 1'b1;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (idx == LAST_IDX) begin
                            last_f <= in_last;
                            idx    <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FEED: begin
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                WAIT: begin
                    if (core_done) begin
                        chain <= core_h_out;
                        first <= 1'b0;
                        if (block_cnt != '1) block_cnt <= block_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        chain     <= SHA256_IV;
                        first     <= 1'b1;
                        block_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Self-checking bench: behavioural SHA-256 core responder plus table, random and corner-case sequences.
module tb_sha256_block_sequencer;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_word;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] digest;
    logic         busy;
    logic [7:0]   block_cnt;
    logic         err;
    logic         core_start;
    logic         core_first;
    logic [31:0]  core_w;
    logic [255:0] core_h_in;
    logic [255:0] core_h_out;
    logic         core_done;
    logic         core_done_m;
    logic         spurious_done;

    int checks = 0;
    int errors = 0;
    bit err_exp = 1'b0;

    logic [255:0] hin_q [$];
    logic [255:0] hout_q [$];
    logic         first_q [$];
    int           unstable = 0;

    assign core_done = core_done_m | spurious_done;

    always #5 clk = ~clk;

    sha256_block_sequencer #(.WORDS_PER_BLOCK(16), .BLOCK_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .digest(digest), .busy(busy),
        .block_cnt(block_cnt), .err(err), .core_start(core_start), .core_first(core_first),
        .core_w(core_w), .core_h_in(core_h_in), .core_h_out(core_h_out), .core_done(core_done)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain FIPS 180-4 compression, including the final feed-forward addition.
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
    endfunction

    // Core responder: collects 16 words after core_start, replies after 1..4 cycles.
    initial begin : core_model
        logic [511:0] cblk;
        logic [255:0] ch;
        logic         cf;
        bit           abort;
        int           lat;
        core_done_m = 1'b0;
        core_h_out  = '0;
        forever begin
            @(posedge clk); #1;
            if (reset && core_start) begin
                abort = 1'b0;
                ch = core_h_in;
                cf = core_first;
                cblk[511 -: 32] = core_w;
                for (int k = 1; k < 16; k++) begin
                    @(posedge clk); #1;
                    if (!reset) begin abort = 1'b1; break; end
                    cblk[511-32*k -: 32] = core_w;
                    if (core_h_in !== ch || core_first !== cf) unstable++;
                end
                if (!abort) begin
                    lat = $urandom_range(1, 4);
                    for (int k = 0; k < lat; k++) begin
                        @(posedge clk); #1;
                        if (!reset) begin abort = 1'b1; break; end
                        if (core_h_in !== ch || core_first !== cf) unstable++;
                    end
                end
                if (!abort) begin
                    core_h_out  = compress(ch, cblk);
                    core_done_m = 1'b1;
                    hin_q.push_back(ch);
                    first_q.push_back(cf);
                    hout_q.push_back(core_h_out);
                    @(posedge clk); #1;
                    core_done_m = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 500) begin
            in_valid = 1'b0;
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
    endtask

    task automatic send_words(input logic [511:0] blk, input bit last, input bit gaps, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    in_valid = 1'b0;
                    in_word  = $urandom;
                    in_last  = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            wait_ready();
            in_valid = 1'b1;
            in_word  = blk[511-32*i -: 32];
            if (i == 15) in_last = last;
            else in_last = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_digest(input string nm, input logic [255:0] exp_dig, input int exp_cnt,
                               input int hold, input bit poke);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        check({nm, "_out_valid"}, 256'(out_valid), 256'(1));
        check({nm, "_digest"}, digest, exp_dig);
        check({nm, "_block_cnt"}, 256'(block_cnt), 256'(exp_cnt));
        check({nm, "_err"}, 256'(err), 256'(err_exp));
        for (int i = 0; i < hold; i++) begin
            spurious_done = poke && (i == 2);
            tick();
            spurious_done = 1'b0;
            check({nm, "_hold_valid"}, 256'(out_valid), 256'(1));
            check({nm, "_hold_digest"}, digest, exp_dig);
            check({nm, "_hold_in_ready"}, 256'(in_ready), 256'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, "_post_valid"}, 256'(out_valid), 256'(0));
        check({nm, "_post_in_ready"}, 256'(in_ready), 256'(1));
        check({nm, "_post_h_in"}, core_h_in, IV);
        check({nm, "_post_cnt"}, 256'(block_cnt), 256'(0));
    endtask

    task automatic check_chain(input string nm, input int nblk);
        check({nm, "_core_blocks"}, 256'(first_q.size()), 256'(nblk));
        if (first_q.size() == nblk) begin
            check({nm, "_first0"}, 256'(first_q[0]), 256'(1));
            check({nm, "_h_in0"}, hin_q[0], IV);
            for (int b = 1; b < nblk; b++) begin
                check({nm, "_firstN"}, 256'(first_q[b]), 256'(0));
                check({nm, "_h_chain"}, hin_q[b], hout_q[b-1]);
            end
        end
    endtask

    typedef struct {
        int           nblk;
        logic [1023:0] msg;
        logic [255:0] dig;
        int           cnt;
    } vec_t;

    initial begin : main
        vec_t         vecs [3];
        logic [511:0] abc_blk;
        logic [511:0] blk;
        logic [255:0] h;
        int           nb;

        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        vecs[0] = '{1, {abc_blk, 512'h0},
                    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, 1};
        vecs[1] = '{1, {32'h80000000, 480'h0, 512'h0},
                    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855, 1};
        vecs[2] = '{2, {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                        32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                        32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000,
                        32'h00000000, 448'h0, 32'h00000000, 32'h000001c0},
                    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1, 2};

        reset = 1'b0; in_valid = 1'b0; in_word = '0; in_last = 1'b0;
        out_ready = 1'b0; spurious_done = 1'b0;
        tick(); tick();
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_digest", digest, 256'(0));
        check("rst_h_in", core_h_in, IV);
        check("rst_core_start", 256'(core_start), 256'(0));
        check("rst_core_first", 256'(core_first), 256'(0));
        check("rst_core_w", 256'(core_w), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_cnt", 256'(block_cnt), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        reset = 1'b1;
        tick();

        for (int v = 0; v < 3; v++) begin
            hin_q.delete(); hout_q.delete(); first_q.delete();
            for (int b = 0; b < vecs[v].nblk; b++)
                send_words(vecs[v].msg[1023-512*b -: 512], b == vecs[v].nblk - 1, 1'b0, 0, 15);
            wait_digest($sformatf("vec%0d", v), vecs[v].dig, vecs[v].cnt, 0, 1'b0);
            check_chain($sformatf("vec%0d", v), vecs[v].nblk);
        end

        for (int r = 0; r < 4; r++) begin
            nb = $urandom_range(1, 3);
            h  = IV;
            hin_q.delete(); hout_q.delete(); first_q.delete();
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = $urandom;
                h = compress(h, blk);
                send_words(blk, b == nb - 1, 1'b1, 0, 15);
            end
            wait_digest($sformatf("rand%0d", r), h, nb, $urandom_range(0, 3), 1'b0);
            check_chain($sformatf("rand%0d", r), nb);
        end

        send_words(abc_blk, 1'b1, 1'b1, 0, 15);
        wait_digest("backpressure", vecs[0].dig, 1, 10, 1'b0);

        // Abort partway through FEED: the core has seen words 0..7 only.
        send_words(abc_blk, 1'b1, 1'b0, 0, 15);
        repeat (7) tick();
        #2 reset = 1'b0;
        tick(); tick();
        check("rstfeed_core_start", 256'(core_start), 256'(0));
        check("rstfeed_out_valid", 256'(out_valid), 256'(0));
        check("rstfeed_in_ready", 256'(in_ready), 256'(1));
        check("rstfeed_cnt", 256'(block_cnt), 256'(0));
        check("rstfeed_h_in", core_h_in, IV);
        #1 reset = 1'b1;
        tick();
        send_words(abc_blk, 1'b1, 1'b0, 0, 15);
        wait_digest("after_reset", vecs[0].dig, 1, 0, 1'b0);

        send_words(abc_blk, 1'b1, 1'b0, 0, 4);
        spurious_done = 1'b1;
        tick();
        spurious_done = 1'b0;
        err_exp = 1'b1;
        check("spur_err", 256'(err), 256'(1));
        check("spur_in_ready", 256'(in_ready), 256'(1));
        check("spur_busy", 256'(busy), 256'(1));
        send_words(abc_blk, 1'b1, 1'b0, 5, 15);
        wait_digest("spurious", vecs[0].dig, 1, 5, 1'b1);
        check("spur_err_sticky", 256'(err), 256'(1));

        // Long message drives the block counter past its saturation point.
        h = IV;
        for (int b = 0; b < 257; b++) begin
            for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = $urandom;
            h = compress(h, blk);
            send_words(blk, b == 256, 1'b0, 0, 15);
        end
        wait_digest("saturate", h, 255, 0, 1'b0);

        check("h_in_first_stable", 256'(unstable), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_block_sequencer.md
Name: sha256_block_sequencer

Overview:
Controller that sequences the iterative SHA-256 compression core (`naive`) across multi-block messages. It buffers one 512-bit block from a word-serial host stream and issues it to the core. It streams W0..W15 to the core, chains each block's H output into the next block's H input, and presents the final 256-bit digest through a valid/ready handshake. It sits between the host/padding logic and the core and is the core's only driver.

Parameters:
WORDS_PER_BLOCK, 16, message words per block; fixed by SHA-256 and not to be overridden.
BLOCK_CNT_W, 8, width of the processed-block counter.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  host word valid.
in_ready  out  1  sequencer can accept a word.
in_word  in  32  message word, big-endian word order, already padded.
in_last  in  1  final block of the message; sampled only with word 15 of a block.
out_valid  out  1  digest valid.
out_ready  in  1  host accepts the digest.
digest  out  256  final hash, H0 in [255:224].
busy  out  1  high in every state except LOAD with zero words buffered and first=1.
block_cnt  out  BLOCK_CNT_W  blocks completed in the current message.
err  out  1  sticky protocol error.
core_start  out  1  one-cycle start pulse to the core.
core_first  out  1  drives the core's block_count input; 1 for the first block of a message.
core_w  out  32  message word to the core.
core_h_in  out  256  chaining value to the core.
core_h_out  in  256  updated hash from the core (core performs the final addition).
core_done  in  1  core completion pulse.

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-low. Asserting it mid-operation aborts the message.
- Reset values: state=LOAD, first=1, chain=IV, word index=0, block_cnt=0, err=0. All outputs 0, except in_ready=1 and core_h_in=IV.
- IV constant: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- LOAD state:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready writes buf[idx] and increments idx.
  - On the 16th accepted word, latch in_last into last_f, clear idx, and go to FEED.
- FEED state (16 cycles):
  - Drive core_w=buf[idx], idx 0..15.
  - core_start=1 only in the first FEED cycle.
  - core_first=first.
  - core_h_in=chain, held stable through FEED and WAIT.
  - After idx=15, go to WAIT.
  - in_ready=0.
- WAIT state:
  - Stay until core_done=1.
  - On core_done: chain<=core_h_out, block_cnt++ (saturating at all-ones), first<=0.
  - If last_f, go to OUT; otherwise go to LOAD.
- OUT state:
  - out_valid=1 and digest=chain, both held stable until out_ready.
  - On out_valid&&out_ready: go to LOAD with chain=IV, first=1, block_cnt=0.
  - out_valid deasserts the cycle after the handshake.
- Latency: first word of FEED follows the cycle after word 15 is accepted; core_done-to-out_valid is 1 cycle.
- Core protocol violations:
  - core_done in LOAD, FEED or OUT: ignored, and err is set.
  - core_done in the same cycle as core_start: ignored, and err is set.
  - err clears only on reset.
- Host side:
  - in_valid gaps stall LOAD with no effect on buffered words.
  - in_last on words 0..14 is ignored.
- Registered outputs: digest, core_h_in and core_w are registered (or driven from registered buffer state) so there is no combinational path from in_* to core_*.

Decomposition:
- Package sha256_pkg holds:
  - SHA256_IV (logic [255:0]).
  - WORDS_PER_BLOCK.
  - The typedef for the state enum: LOAD, FEED, WAIT, OUT.
  - The typedef word_t (logic [31:0]).
- One sub-module, sha256_block_buf: a 16x32 register file with write port (we, waddr, wdata) and async read port (raddr). It is reused later by the pipelined core.

Test Plan:
- Single block "abc": host words 61626380, 00000000 x14, 00000018 with in_last=1, driven against the real core. Required: digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; block_cnt=1; err=0.
- Empty message: 80000000, then zeros, with word 15=0 and in_last=1. Required: digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block 448-bit "abcdbcdecdefdefg…nopq" message, with in_last only on block 2. Required:
  - digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - block_cnt=2.
  - core_first=1 then 0.
  - core_h_in for block 2 equals block 1's core_h_out.
- Backpressure and gaps:
  - Random in_valid gaps leave the "abc" digest unchanged.
  - out_ready held low 10 cycles keeps out_valid=1, digest stable and in_ready=0.
  - After the handshake, in_ready=1 and core_h_in=IV.
- Reset mid-FEED (idx=7): assert reset for 2 cycles. Required:
  - core_start=0, out_valid=0, in_ready=1, block_cnt=0.
  - A following "abc" message hashes correctly.
- Spurious core_done in LOAD: err=1 and stays 1; state, buffer and later digest are unaffected.
